// File: rtl/rgb_mixer_pkg.sv
// Shared constants for the RGB mixer front end: default widths/debounce
// timing and the quadrature direction encoding.
package rgb_mixer_pkg;

  localparam int unsigned DEFAULT_WIDTH        = 8;
  localparam int unsigned DEFAULT_DEBOUNCE_DIV = 16;
  localparam int unsigned DEFAULT_DEBOUNCE_LEN = 4;

  // Debounced B level seen at the debounced-A rising edge
  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

endpackage : rgb_mixer_pkg

// File: rtl/debounce.sv
// One encoder channel: 2-flop synchroniser, strobe-sampled shift register
// and hysteretic debounced level.
module debounce #(
  parameter int unsigned DEBOUNCE_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic raw,
  output logic level
);

  logic                    sync_q1;
  logic                    sync_q2;
  logic [DEBOUNCE_LEN-1:0] hist_q;
  logic [DEBOUNCE_LEN-1:0] hist_next;
  logic                    level_next;

  // Raw inputs are asynchronous; idle high, so flops reset to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    hist_next  = hist_q;
    level_next = level;
    if (strobe) begin
      hist_next = {hist_q[DEBOUNCE_LEN-2:0], sync_q2};
      if (&hist_next) begin
        level_next = 1'b1;
      end else if (~|hist_next) begin
        level_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '1;
      level  <= 1'b1;
    end else begin
      hist_q <= hist_next;
      level  <= level_next;
    end
  end

endmodule : debounce

// File: rtl/quad_encoder.sv
// Quadrature rotary-encoder front end: debounces both channels on a shared
// prescaler strobe, decodes 1x detents on debounced-A rise, updates value.
module quad_encoder
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned STEP         = 1,
  parameter bit          SATURATE     = 1'b0,
  parameter int unsigned RESET_VALUE  = 0,
  parameter int unsigned DEBOUNCE_DIV = DEFAULT_DEBOUNCE_DIV,
  parameter int unsigned DEBOUNCE_LEN = DEFAULT_DEBOUNCE_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] value,
  output logic             changed
);

  localparam int unsigned CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam int unsigned EXT_W = WIDTH + 1;

  logic [CNT_W-1:0] presc_q;
  logic             strobe;
  logic             deb_a;
  logic             deb_b;
  logic             prev_a;
  logic             detent;
  logic [EXT_W-1:0] sum;
  logic [EXT_W-1:0] diff;
  logic [WIDTH-1:0] value_next;
  logic             changed_next;

  // Shared prescaler keeps both channels sampling on the same cycle
  assign strobe = (presc_q == CNT_W'(DEBOUNCE_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (strobe) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + CNT_W'(1);
    end
  end

  debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN)
  ) u_deb_a (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe),
    .raw    (enc_a),
    .level  (deb_a)
  );

  debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN)
  ) u_deb_b (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe),
    .raw    (enc_b),
    .level  (deb_b)
  );

  assign detent = deb_a & ~prev_a;

  // Arithmetic one bit wider so the carry/borrow flags the limit crossing
  always_comb begin
    value_next   = value;
    changed_next = 1'b0;
    sum          = {1'b0, value} + EXT_W'(STEP);
    diff         = {1'b0, value} - EXT_W'(STEP);
    if (detent) begin
      if (deb_b == DIR_CW) begin
        value_next = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
      end else begin
        value_next = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      end
      changed_next = (value_next != value);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_a  <= 1'b1;
      value   <= WIDTH'(RESET_VALUE);
      changed <= 1'b0;
    end else begin
      prev_a  <= deb_a;
      value   <= value_next;
      changed <= changed_next;
    end
  end

endmodule : quad_encoder

// File: tb/tb_quad_encoder.sv
// Directed bench: three encoder instances (wrapping, saturating, saturating
// STEP=5 from 253) driven by the same A/B waveforms.
module tb_quad_encoder;

  logic       clk;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic [7:0] value_w, value_s, value_5;
  logic       changed_w, changed_s, changed_5;

  int checks   = 0;
  int failures = 0;

  int pulses_w = 0, pulses_s = 0, pulses_5 = 0;
  int wide_pulses = 0;
  logic prev_cw = 1'b0, prev_cs = 1'b0, prev_c5 = 1'b0;
  int snap_w, snap_s, snap_5;

  quad_encoder #(.WIDTH(8), .STEP(1), .SATURATE(1'b0), .RESET_VALUE(0),
                 .DEBOUNCE_DIV(4), .DEBOUNCE_LEN(3)) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .value(value_w), .changed(changed_w));

  quad_encoder #(.WIDTH(8), .STEP(1), .SATURATE(1'b1), .RESET_VALUE(0),
                 .DEBOUNCE_DIV(4), .DEBOUNCE_LEN(3)) dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .value(value_s), .changed(changed_s));

  quad_encoder #(.WIDTH(8), .STEP(5), .SATURATE(1'b1), .RESET_VALUE(253),
                 .DEBOUNCE_DIV(4), .DEBOUNCE_LEN(3)) dut_5 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .value(value_5), .changed(changed_5));

  always #5 clk = ~clk;

  // Pulse counting and one-cycle-width tracking, sampled on the falling edge
  always @(negedge clk) begin
    if (changed_w) pulses_w++;
    if (changed_s) pulses_s++;
    if (changed_5) pulses_5++;
    if ((changed_w && prev_cw) || (changed_s && prev_cs) || (changed_5 && prev_c5))
      wide_pulses++;
    prev_cw = changed_w;
    prev_cs = changed_s;
    prev_c5 = changed_5;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic snapshot();
    snap_w = pulses_w;
    snap_s = pulses_s;
    snap_5 = pulses_5;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
  endtask

  task automatic cw_detent();
    enc_b = 1'b0; wait_clk(40);
    enc_a = 1'b0; wait_clk(40);
    enc_a = 1'b1; wait_clk(40);
    enc_b = 1'b1; wait_clk(40);
  endtask

  task automatic ccw_detent();
    enc_a = 1'b0; wait_clk(40);
    enc_a = 1'b1; wait_clk(40);
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    enc_a = 1'b1;
    enc_b = 1'b1;

    // Reset with inputs idle
    wait_clk(5);
    check("reset_value_w", int'(value_w), 0);
    check("reset_value_5", int'(value_5), 253);
    check("reset_changed", int'({changed_w, changed_s, changed_5}), 0);
    reset = 1'b0;
    snapshot();
    wait_clk(20);
    check("post_reset_pulses", (pulses_w - snap_w) + (pulses_s - snap_s) + (pulses_5 - snap_5), 0);

    // Ten clockwise detents
    snapshot();
    for (int i = 0; i < 10; i++) cw_detent();
    check("cw_value_w", int'(value_w), 10);
    check("cw_pulses_w", pulses_w - snap_w, 10);
    check("cw_value_s", int'(value_s), 10);
    check("cw_pulses_s", pulses_s - snap_s, 10);
    check("cw_value_5_clamped", int'(value_5), 255);
    check("cw_pulses_5", pulses_5 - snap_5, 1);
    check("cw_pulse_width", wide_pulses, 0);

    // One CCW detent from 0: wrap vs clamp
    do_reset();
    snapshot();
    ccw_detent();
    check("wrap_value_w", int'(value_w), 255);
    check("wrap_pulses_w", pulses_w - snap_w, 1);
    check("clamp_low_value_s", int'(value_s), 0);
    check("clamp_low_pulses_s", pulses_s - snap_s, 0);
    check("ccw_value_5", int'(value_5), 248);

    // Saturating up with STEP=5 from 253
    do_reset();
    snapshot();
    cw_detent();
    check("sat_up_value_5", int'(value_5), 255);
    check("sat_up_pulses_5", pulses_5 - snap_5, 1);
    cw_detent();
    check("sat_up2_value_5", int'(value_5), 255);
    check("sat_up2_pulses_5", pulses_5 - snap_5, 1);
    check("sat_up2_value_w", int'(value_w), 2);

    // Short glitches on A and B never reach the debounced levels
    snapshot();
    for (int i = 0; i < 20; i++) begin
      enc_a = 1'b0; wait_clk(6);
      enc_a = 1'b1; wait_clk(14);
      enc_b = 1'b0; wait_clk(6);
      enc_b = 1'b1; wait_clk(14);
    end
    wait_clk(30);
    check("glitch_value_w", int'(value_w), 2);
    check("glitch_value_5", int'(value_5), 255);
    check("glitch_pulses", (pulses_w - snap_w) + (pulses_s - snap_s) + (pulses_5 - snap_5), 0);

    // Reset mid-detent: A low for about one strobe, released with A high
    enc_a = 1'b0;
    wait_clk(8);
    reset = 1'b1;
    wait_clk(3);
    enc_a = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    snapshot();
    wait_clk(60);
    check("midreset_value_w", int'(value_w), 0);
    check("midreset_value_s", int'(value_s), 0);
    check("midreset_value_5", int'(value_5), 253);
    check("midreset_pulses", (pulses_w - snap_w) + (pulses_s - snap_s) + (pulses_5 - snap_5), 0);
    check("final_pulse_width", wide_pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_quad_encoder
